// File: rtl/lightbike_pkg.sv
// lightbike_pkg: shared directions, states, winner codes and start-position helpers.
package lightbike_pkg;
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P0   = 2'b01;
  localparam logic [1:0] WIN_P1   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_PLACE0, S_PLACE1, S_WAIT, S_TURN, S_RD0,
    S_RD1, S_CHK, S_WR0, S_WR1, S_COLLIDE, S_DONE
  } state_e;

  function automatic int start_x0(int gb);
    return (1 << gb) / 4;
  endfunction

  function automatic int start_x1(int gb);
    return 3 * (1 << gb) / 4;
  endfunction

  function automatic int start_y(int gb);
    return (1 << gb) / 2;
  endfunction

  // lat bit0 = left pending, bit1 = right pending; both pending cancel out
  function automatic logic [1:0] apply_turn(logic [1:0] dir, logic [1:0] lat);
    return lat == 2'b01 ? dir - 2'd1 : lat == 2'b10 ? dir + 2'd1 : dir;
  endfunction
endpackage

// File: rtl/lightbike_step.sv
// lightbike_step: one-cell move of a bike head, flagging moves off the grid edge.
module lightbike_step
  import lightbike_pkg::*;
#(
  parameter int GRID_BITS = 8
) (
  input  logic [GRID_BITS-1:0] x_i,
  input  logic [GRID_BITS-1:0] y_i,
  input  logic [1:0]           dir_i,
  output logic [GRID_BITS-1:0] x_o,
  output logic [GRID_BITS-1:0] y_o,
  output logic                 oob_o
);
  localparam logic [GRID_BITS-1:0] MAX = '1;

  always_comb begin
    x_o   = dir_i == DIR_RIGHT ? x_i + 1'b1 : dir_i == DIR_LEFT ? x_i - 1'b1 : x_i;
    y_o   = dir_i == DIR_DOWN ? y_i + 1'b1 : dir_i == DIR_UP ? y_i - 1'b1 : y_i;
    oob_o = (dir_i == DIR_UP && y_i == '0) || (dir_i == DIR_DOWN && y_i == MAX) ||
            (dir_i == DIR_LEFT && x_i == '0) || (dir_i == DIR_RIGHT && x_i == MAX);
  end
endmodule

// File: rtl/lightbike_game_ctrl.sv
// lightbike_game_ctrl: game sequencer owning the occupancy grid RAM;
// clears the grid, steps both bikes per tick, detects collisions and reports the winner.
module lightbike_game_ctrl
  import lightbike_pkg::*;
#(
  parameter int GRID_BITS = 8,
  parameter int CNT_W     = 16
) (
  input  logic                   Clk_i,
  input  logic                   Reset_i,
  input  logic                   Start_i,
  input  logic                   Ack_i,
  input  logic                   Tick_i,
  input  logic                   P0_Left_i,
  input  logic                   P0_Right_i,
  input  logic                   P1_Left_i,
  input  logic                   P1_Right_i,
  output logic [2*GRID_BITS-1:0] Grid_Addr_o,
  output logic                   Grid_We_o,
  output logic                   Grid_Wdata_o,
  input  logic                   Grid_Rdata_i,
  output logic                   q_I_o,
  output logic                   q_Straight_o,
  output logic                   q_Turning_o,
  output logic                   q_Collision_o,
  output logic                   q_Done_o,
  output logic [1:0]             Winner_o,
  output logic [CNT_W-1:0]       Move_Count_o,
  output logic [GRID_BITS-1:0]   P0_X_o,
  output logic [GRID_BITS-1:0]   P0_Y_o,
  output logic [GRID_BITS-1:0]   P1_X_o,
  output logic [GRID_BITS-1:0]   P1_Y_o
);
  localparam int G = GRID_BITS;

  state_e         state_q;
  logic [1:0]     dir0_q, dir1_q, dir0_d, dir1_d;
  logic [1:0]     lat0_q, lat1_q, lat0_d, lat1_d;
  logic [G-1:0]   n0x_q, n0y_q, n1x_q, n1y_q;
  logic [G-1:0]   s0x, s0y, s1x, s1y;
  logic           s0_oob, s1_oob, oob0_q, oob1_q, hit0_q, crash0_q, crash1_q;
  logic           lat_en, same, c0, c1;

  lightbike_step #(.GRID_BITS(G)) u_step0 (
    .x_i(P0_X_o), .y_i(P0_Y_o), .dir_i(dir0_d), .x_o(s0x), .y_o(s0y), .oob_o(s0_oob)
  );
  lightbike_step #(.GRID_BITS(G)) u_step1 (
    .x_i(P1_X_o), .y_i(P1_Y_o), .dir_i(dir1_d), .x_o(s1x), .y_o(s1y), .oob_o(s1_oob)
  );

  always_comb begin
    dir0_d = apply_turn(dir0_q, lat0_q);
    dir1_d = apply_turn(dir1_q, lat1_q);
    lat_en = !(state_q inside {S_IDLE, S_CLEAR});
    lat0_d = lat_en ? ((state_q == S_TURN ? 2'b00 : lat0_q) | {P0_Right_i, P0_Left_i}) : 2'b00;
    lat1_d = lat_en ? ((state_q == S_TURN ? 2'b00 : lat1_q) | {P1_Right_i, P1_Left_i}) : 2'b00;
    same   = {n0y_q, n0x_q} == {n1y_q, n1x_q} && !oob0_q && !oob1_q;
    c0     = oob0_q | hit0_q | same;
    c1     = oob1_q | Grid_Rdata_i | same;
  end

  assign q_I_o         = state_q inside {S_IDLE, S_CLEAR, S_PLACE0, S_PLACE1};
  assign q_Straight_o  = state_q == S_WAIT;
  assign q_Turning_o   = state_q inside {S_TURN, S_RD0, S_RD1, S_CHK, S_WR0, S_WR1};
  assign q_Collision_o = state_q == S_COLLIDE;
  assign q_Done_o      = state_q == S_DONE;

  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q      <= S_IDLE;
      Grid_Addr_o  <= '0;
      Grid_We_o    <= 1'b0;
      Grid_Wdata_o <= 1'b0;
      Winner_o     <= WIN_NONE;
      Move_Count_o <= '0;
      P0_X_o       <= '0;
      P0_Y_o       <= '0;
      P1_X_o       <= '0;
      P1_Y_o       <= '0;
      dir0_q       <= DIR_UP;
      dir1_q       <= DIR_UP;
      lat0_q       <= '0;
      lat1_q       <= '0;
      n0x_q        <= '0;
      n0y_q        <= '0;
      n1x_q        <= '0;
      n1y_q        <= '0;
      oob0_q       <= 1'b0;
      oob1_q       <= 1'b0;
      hit0_q       <= 1'b0;
      crash0_q     <= 1'b0;
      crash1_q     <= 1'b0;
    end else begin
      lat0_q <= lat0_d;
      lat1_q <= lat1_d;
      case (state_q)
        S_IDLE: if (Start_i) begin
          state_q      <= S_CLEAR;
          Move_Count_o <= '0;
          Winner_o     <= WIN_NONE;
          P0_X_o       <= G'(start_x0(G));
          P0_Y_o       <= G'(start_y(G));
          P1_X_o       <= G'(start_x1(G));
          P1_Y_o       <= G'(start_y(G));
          dir0_q       <= DIR_RIGHT;
          dir1_q       <= DIR_LEFT;
          Grid_Addr_o  <= '0;
          Grid_We_o    <= 1'b1;
          Grid_Wdata_o <= 1'b0;
        end
        S_CLEAR: if (&Grid_Addr_o) begin
          state_q      <= S_PLACE0;
          Grid_Addr_o  <= {P0_Y_o, P0_X_o};
          Grid_Wdata_o <= 1'b1;
        end else Grid_Addr_o <= Grid_Addr_o + 1'b1;
        S_PLACE0: begin
          state_q     <= S_PLACE1;
          Grid_Addr_o <= {P1_Y_o, P1_X_o};
        end
        S_PLACE1: begin
          state_q   <= S_WAIT;
          Grid_We_o <= 1'b0;
        end
        S_WAIT: if (Tick_i) state_q <= S_TURN;
        S_TURN: begin
          state_q     <= S_RD0;
          dir0_q      <= dir0_d;
          dir1_q      <= dir1_d;
          n0x_q       <= s0x;
          n0y_q       <= s0y;
          n1x_q       <= s1x;
          n1y_q       <= s1y;
          oob0_q      <= s0_oob;
          oob1_q      <= s1_oob;
          Grid_Addr_o <= {s0y, s0x};
        end
        S_RD0: begin
          state_q     <= S_RD1;
          Grid_Addr_o <= {n1y_q, n1x_q};
        end
        S_RD1: begin
          state_q <= S_CHK;
          hit0_q  <= Grid_Rdata_i;
        end
        S_CHK: begin
          crash0_q <= c0;
          crash1_q <= c1;
          if (!c0 && !c1) begin
            state_q     <= S_WR0;
            Grid_Addr_o <= {n0y_q, n0x_q};
            Grid_We_o   <= 1'b1;
          end else state_q <= S_COLLIDE;
        end
        S_WR0: begin
          state_q     <= S_WR1;
          Grid_Addr_o <= {n1y_q, n1x_q};
        end
        S_WR1: begin
          state_q      <= S_WAIT;
          Grid_We_o    <= 1'b0;
          P0_X_o       <= n0x_q;
          P0_Y_o       <= n0y_q;
          P1_X_o       <= n1x_q;
          P1_Y_o       <= n1y_q;
          Move_Count_o <= &Move_Count_o ? Move_Count_o : Move_Count_o + 1'b1;
        end
        S_COLLIDE: begin
          state_q  <= S_DONE;
          Winner_o <= {crash0_q, crash1_q};
        end
        S_DONE: if (Ack_i) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
